ama_pipe_adder: RTL
===================

Name: ama_pipe_adder

Overview:
- Parametrised, pipelined successor to the fixed 24-bit, 6-LSB approximate mirror adder.
- A WIDTH-bit adder whose APPR_BITS least-significant positions use approximate mirror-adder cells (type 4), selectable per transaction between approximate and exact mode.
- Adds a valid/ready streaming interface, a configurable pipeline depth, a per-result absolute-error output and a saturating error-event counter.
- Sits in the approximate datapath library as the drop-in adder for DFG-scheduled accelerators.

Parameters:
- WIDTH, 24, operand and sum width (>= 2).
- APPR_BITS, 6, number of LSB positions using approximate cells (0..WIDTH).
- STAGES, 2, pipeline register stages, i.e. latency in cycles (1..4).
- CNT_W, 16, width of the error-event counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- appr_en  input  1  1 = approximate LSBs, 0 = exact add; sampled with the beat.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- s  output  WIDTH  sum.
- cout  output  1  carry out.
- err_mag  output  WIDTH+1  |{exact cout,s} - {cout,s}| for this beat.
- err_cnt  output  CNT_W  count of delivered beats with err_mag != 0.
- err_clr  input  1  synchronous clear of err_cnt.

Behaviour:
- Reset (rst_n=0 at clock edge): all pipeline valid bits are 0, so out_valid=0. s, cout and err_mag are 0; err_cnt is 0. in_ready=1 in the first cycle after reset. Reset mid-operation discards all in-flight beats, with no output for them.
- Approximate cell at bit i < APPR_BITS, when appr_en=1:
  - s_i = a_i ? c_i : b_i
  - c_{i+1} = a_i
- Bits >= APPR_BITS: exact full-add, chained from c_{APPR_BITS}.
- With appr_en=0, every bit is an exact full-add, so {cout,s} = a+b+cin mod 2^(WIDTH+1).
- The exact reference sum is always computed in parallel; err_mag is the unsigned absolute difference on WIDTH+1 bits.
- Pipeline:
  - STAGES register slices; any carry-chain split point is allowed.
  - A beat accepted at edge N (in_valid & in_ready) appears with out_valid=1 after edge N+STAGES-1 when there is no stall.
  - appr_en travels with its beat.
- Handshake:
  - in_ready = ~out_valid | out_ready; the whole pipe advances or stalls together.
  - While out_valid & ~out_ready, the outputs s, cout and err_mag hold stable and no internal stage changes.
  - Bubbles (in_valid=0) propagate as invalid slots; output registers hold their last values when out_valid=0.
  - Throughput is 1 beat/cycle with out_ready held at 1.
- err_cnt:
  - Increments by 1 on each output handshake (out_valid & out_ready) with err_mag != 0.
  - Saturates at 2^CNT_W - 1.
  - err_clr has priority over an increment in the same cycle; the result is 0 and that beat is not counted.
- APPR_BITS=0: the approximate path equals the exact path, so err_mag is always 0.
- APPR_BITS=WIDTH: cout = a_{WIDTH-1} in approximate mode.

Test Plan:
- Case 1, WIDTH=24, APPR_BITS=6, appr_en=1: a=0x00003F, b=0x000001, cin=0 → s=0x00007E, cout=0, err_mag=62. err_cnt becomes 1 after the output handshake.
- Case 2, same parameters, appr_en=1: a=0x000000, b=0x00003F, cin=1 → s=0x00003F, err_mag=1.
- Case 3, exact mode, appr_en=0:
  - a=0x00003F, b=0x000001 → s=0x000040, err_mag=0, err_cnt unchanged.
  - a=0xFFFFFF, b=0x000001 → s=0x000000, cout=1.
- Case 4, latency and throughput: STAGES=2, stream 8 back-to-back beats with out_ready=1 → first out_valid one cycle after the first accept, then 8 consecutive valid cycles in order.
- Case 5, backpressure: drop out_ready for 3 cycles mid-stream → in_ready=0 during the stall, outputs frozen, no beat lost or duplicated, order preserved.
- Case 6, reset and counter edges:
  - CNT_W=2: four erroneous beats → err_cnt saturates at 3.
  - err_clr asserted together with an erroneous handshake → err_cnt=0.
  - rst_n=0 with beats in flight → out_valid=0 next cycle and those beats never emerge.

Source files
------------

// File: rtl/ama_pipe_adder.sv
// rtl/ama_pipe_adder.sv - pipelined approximate mirror adder (type 4 LSB cells)
// with valid/ready streaming, per-beat error magnitude and saturating error counter.
module ama_pipe_adder #(
  parameter int WIDTH     = 24,
  parameter int APPR_BITS = 6,
  parameter int STAGES    = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             appr_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [WIDTH:0]   err_mag,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam int DW = 2 * WIDTH + 2;

  logic [WIDTH:0]  exact_sum;
  logic [WIDTH:0]  appr_sum;
  logic [WIDTH:0]  diff;
  logic            carry;
  logic [DW-1:0]   beat;
  logic [STAGES-1:0] vld;
  logic [DW-1:0]   data [STAGES];

  // The whole sum and its error are formed before the first slice; later slices only delay.
  always_comb begin
    exact_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    appr_sum  = '0;
    carry     = cin;
    for (int i = 0; i < WIDTH; i++) begin
      if (appr_en && (i < APPR_BITS)) begin
        appr_sum[i] = a[i] ? carry : b[i];
        carry       = a[i];
      end else begin
        appr_sum[i] = a[i] ^ b[i] ^ carry;
        carry       = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
    end
    appr_sum[WIDTH] = carry;
    diff = (exact_sum >= appr_sum) ? (exact_sum - appr_sum) : (appr_sum - exact_sum);
  end

  assign beat      = {appr_sum[WIDTH-1:0], appr_sum[WIDTH], diff};
  assign out_valid = vld[STAGES-1];
  assign in_ready  = ~out_valid | out_ready;
  assign s         = data[STAGES-1][DW-1 -: WIDTH];
  assign cout      = data[STAGES-1][WIDTH+1];
  assign err_mag   = data[STAGES-1][WIDTH:0];

  // Payload registers only load on a valid slot so bubbles leave the last result visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) data[i] <= '0;
    end else if (in_ready) begin
      vld[0] <= in_valid;
      if (in_valid) data[0] <= beat;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) data[i] <= data[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && (err_mag != '0) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
